// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over valid/ready and
// streams it LSB first with first/last strobes, back-to-back words without bubbles.
module word_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_first,
  output logic             ser_last,
  output logic             ser_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_ser_bit;
  logic             r_ser_first;
  logic             r_ser_last;
  logic             r_ser_valid;

  logic w_at_last;
  logic w_in_ready;
  logic w_accept;

  // Acceptance depends on state only, so in_ready reads high throughout reset.
  always_comb begin
    w_at_last  = (r_cnt == LAST_CNT);
    w_in_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_at_last);
    w_accept   = in_valid && w_in_ready;
  end

  // Single FSM: outputs are registered alongside the shift state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      r_ser_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= SHIFT;
      r_cnt       <= '0;
      r_shreg     <= in_data;
      r_ser_bit   <= in_data[0];
      r_ser_first <= 1'b1;
      r_ser_last  <= 1'b0;
      r_ser_valid <= 1'b1;
    end else begin
      case (r_state)
        SHIFT: begin
          if (!w_at_last) begin
            // Next output bit is shreg[1], visible once the shift lands.
            r_state     <= SHIFT;
            r_cnt       <= r_cnt + ONE_CNT;
            r_shreg     <= {1'b0, r_shreg[WIDTH-1:1]};
            r_ser_bit   <= r_shreg[1];
            r_ser_first <= 1'b0;
            r_ser_last  <= ((r_cnt + ONE_CNT) == LAST_CNT);
            r_ser_valid <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shreg     <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_ser_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_shreg     <= '0;
          r_ser_bit   <= 1'b0;
          r_ser_first <= 1'b0;
          r_ser_last  <= 1'b0;
          r_ser_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign ser_bit   = r_ser_bit;
  assign ser_first = r_ser_first;
  assign ser_last  = r_ser_last;
  assign ser_valid = r_ser_valid;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer (WIDTH=4): stimulus queues expected bits,
// a negedge monitor checks them plus a model of the serial negation stage.
module tb_word_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_first;
  logic       ser_last;
  logic       ser_valid;

  word_serializer #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_bit  (ser_bit),
    .ser_first(ser_first),
    .ser_last (ser_last),
    .ser_valid(ser_valid)
  );

  typedef struct {
    logic b;
    logic f;
    logic l;
    int   gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] neg_q[$];
  int         checks = 0;
  int         errors = 0;

  int         idle_run = 0;
  logic       inv = 1'b0;
  logic [3:0] acc = 4'b0000;
  int         bitpos = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle, valid bits are popped from the scoreboard, idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    logic o;
    logic [3:0] en;
    if (ser_valid === 1'b1) begin
      checks++;
      if (in_ready !== ser_last) begin
        errors++;
        $display("FAIL ready_in_shift: in_ready=%b ser_last=%b required in_ready=%b", in_ready, ser_last, ser_last);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: bit=%b first=%b last=%b with nothing expected", ser_bit, ser_first, ser_last);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({ser_bit, ser_first, ser_last} !== {e.b, e.f, e.l}) begin
          errors++;
          $display("FAIL ser_bit_first_last: got %b%b%b required %b%b%b", ser_bit, ser_first, ser_last, e.b, e.f, e.l);
        end
        if (e.f && (e.gap >= 0)) begin
          checks++;
          if (idle_run != e.gap) begin
            errors++;
            $display("FAIL idle_gap: got %0d idle cycles required %0d", idle_run, e.gap);
          end
        end
      end
      if (ser_first) begin
        inv    = 1'b0;
        acc    = 4'b0000;
        bitpos = 0;
      end
      o = ser_bit ^ inv;
      inv = inv | ser_bit;
      if (bitpos < 4) acc[bitpos] = o;
      bitpos++;
      if (ser_last) begin
        checks++;
        if (neg_q.size() == 0) begin
          errors++;
          $display("FAIL neg_stage: word %b completed with nothing expected", acc);
        end else begin
          en = neg_q.pop_front();
          if (acc !== en) begin
            errors++;
            $display("FAIL neg_stage: got %b required %b", acc, en);
          end
        end
      end
      idle_run = 0;
    end else begin
      checks++;
      if ({ser_bit, ser_first, ser_last, ser_valid, in_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL idle_outputs: bit/first/last/valid/ready=%b required 00001",
                 {ser_bit, ser_first, ser_last, ser_valid, in_ready});
      end
      idle_run++;
    end
  end

  // Offer word w until accepted; queue its bits and its serial negation.
  task automatic send(input logic [3:0] w, input logic [3:0] neg, input int gap);
    exp_t e;
    logic ok;
    int   n;
    for (int i = 0; i < 4; i++) begin
      e.b   = w[i];
      e.f   = (i == 0);
      e.l   = (i == 3);
      e.gap = (i == 0) ? gap : -1;
      exp_q.push_back(e);
    end
    neg_q.push_back(neg);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %b not accepted after %0d cycles", w, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'b0000;
    #1;
    checks++;
    if ({ser_bit, ser_first, ser_last, ser_valid, in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state: bit/first/last/valid/ready=%b required 00001",
               {ser_bit, ser_first, ser_last, ser_valid, in_ready});
    end
    #11;
    rst_n = 1'b1;
    idle(2);

    // Single word 0101 -> 1,0,1,0
    send(4'b0101, 4'b1011, -1);
    idle(8);

    // Back-to-back 0101, 1100 -> 1,0,1,0,0,0,1,1 contiguous
    send(4'b0101, 4'b1011, -1);
    send(4'b1100, 4'b0100, 0);
    idle(8);

    // 1111 offered during bits 0..2 of 0011 is held off until the ser_last edge
    send(4'b0011, 4'b1101, -1);
    send(4'b1111, 4'b0001, 0);
    idle(8);

    // A short in_valid pulse mid-word must be ignored entirely
    send(4'b0101, 4'b1011, -1);
    in_data  = 4'b1110;
    in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    idle(8);

    // Two words of 1000 separated by exactly 3 idle cycles
    send(4'b1000, 4'b1000, -1);
    idle(6);
    send(4'b1000, 4'b1000, 3);
    idle(8);

    // Reset during bit 1 of 1010 drops the word; 0110 then goes out cleanly
    send(4'b1010, 4'b0110, -1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    neg_q.delete();
    #1;
    checks++;
    if ({ser_bit, ser_first, ser_last, ser_valid, in_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_midword: bit/first/last/valid/ready=%b required 00001",
               {ser_bit, ser_first, ser_last, ser_valid, in_ready});
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(4'b0110, 4'b1010, -1);
    idle(8);

    // Negation stage integration: 1010,0100,1101 -> 0110,1100,0011
    send(4'b1010, 4'b0110, -1);
    send(4'b0100, 4'b1100, 0);
    send(4'b1101, 4'b0011, 0);

    n = 0;
    while ((exp_q.size() != 0 || neg_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    idle(4);
    checks++;
    if (exp_q.size() != 0 || neg_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d bits and %0d words still expected, required 0", exp_q.size(), neg_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
